// File: rtl/store_buffer_if.sv
// Store buffer bus: memory-stage store/load ports, dcache drain port, and status.
// Handshakes: a store transfers on a clock edge where st_valid & st_ready; a drain
// pops on an edge where drain_req & drain_ack; loads are single-cycle combinational probes.
interface store_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [1:0]        st_size;
  logic              st_ready;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [1:0]        ld_size;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;
  logic              ld_conflict;

  logic              cache_busy;
  logic              drain_req;
  logic [ADDR_W-1:0] drain_addr;
  logic [DATA_W-1:0] drain_data;
  logic [3:0]        drain_be;
  logic              drain_ack;

  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  dbg_count;

  modport master (
    output st_valid, st_addr, st_data, st_size,
    output ld_valid, ld_addr, ld_size,
    output cache_busy, drain_ack,
    input  st_ready, ld_hit, ld_data, ld_conflict,
    input  drain_req, drain_addr, drain_data, drain_be,
    input  empty, full, dbg_count
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_size,
    input  ld_valid, ld_addr, ld_size,
    input  cache_busy, drain_ack,
    output st_ready, ld_hit, ld_data, ld_conflict,
    output drain_req, drain_addr, drain_data, drain_be,
    output empty, full, dbg_count
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer: one-cycle store accept, program-order drain to the dcache
// when the memory stage leaves the port free, and youngest-first load forwarding.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          rst,
  store_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_W - 2;

  logic [DEPTH-1:0]  valid_q;
  logic [WA_W-1:0]   addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [3:0]        be_q   [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              full, empty, push, pop;
  logic [3:0]        st_be, ld_mask;
  logic [DATA_W-1:0] st_lanes;

  function automatic logic [3:0] lane_mask(input logic [1:0] a, input logic [1:0] size);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << a;
      2'b01:   m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A full buffer never accepts, even when the head pops on the same edge.
  assign push = bus.st_valid & ~full;
  assign pop  = bus.drain_req & bus.drain_ack;

  assign st_be   = lane_mask(bus.st_addr[1:0], bus.st_size);
  assign ld_mask = lane_mask(bus.ld_addr[1:0], bus.ld_size);

  always_comb begin
    case (bus.st_size)
      2'b00:   st_lanes = {4{bus.st_data[7:0]}};
      2'b01:   st_lanes = {2{bus.st_data[15:0]}};
      default: st_lanes = bus.st_data;
    endcase
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // Push and pop never target the same slot: pop needs !empty, push needs !full.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (pop)  valid_q[head_q] <= 1'b0;
      if (push) valid_q[tail_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= bus.st_addr[ADDR_W-1:2];
      data_q[tail_q] <= st_lanes;
      be_q[tail_q]   <= st_be;
    end
  end

  assign bus.st_ready   = ~full;
  assign bus.empty      = empty;
  assign bus.full       = full;
  assign bus.dbg_count  = count_q;
  assign bus.drain_req  = ~empty & ~bus.cache_busy;
  assign bus.drain_addr = {addr_q[head_q], 2'b00};
  assign bus.drain_data = data_q[head_q];
  assign bus.drain_be   = be_q[head_q];

  // Youngest-first scan: the first overlapping entry decides hit versus conflict.
  logic              fwd_found, fwd_hit, fwd_conflict;
  logic [DATA_W-1:0] fwd_data;
  logic [PTR_W-1:0]  idx;
  logic [3:0]        ovl;

  always_comb begin
    fwd_found    = 1'b0;
    fwd_hit      = 1'b0;
    fwd_conflict = 1'b0;
    fwd_data     = '0;
    idx          = '0;
    ovl          = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = tail_q - PTR_W'(i + 1);
      ovl = be_q[idx] & ld_mask;
      if (!fwd_found && valid_q[idx] &&
          (addr_q[idx] == bus.ld_addr[ADDR_W-1:2]) && (ovl != 4'b0000)) begin
        fwd_found = 1'b1;
        if (ovl == ld_mask) begin
          fwd_hit  = 1'b1;
          fwd_data = data_q[idx];
        end else begin
          fwd_conflict = 1'b1;
        end
      end
    end
  end

  assign bus.ld_hit      = bus.ld_valid & fwd_hit;
  assign bus.ld_conflict = bus.ld_valid & fwd_conflict;
  assign bus.ld_data     = (bus.ld_valid & fwd_hit) ? fwd_data : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: expected drains and load responses are queued at
// stimulus time and popped by monitors whenever the DUT presents them.
module tb_store_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // {addr, data, be} for drains; {hit, conflict, data} for loads
  logic [67:0] exp_q[$];
  logic [33:0] ld_q[$];

  store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drain monitor
  always @(negedge clk) begin
    if (!rst && bus.drain_req && bus.drain_ack) begin
      if (exp_q.size() == 0) begin
        chk("drain_unexpected", {bus.drain_addr, bus.drain_data, bus.drain_be}, 68'h0);
      end else begin
        chk("drain", {bus.drain_addr, bus.drain_data, bus.drain_be}, exp_q.pop_front());
      end
    end
  end

  // Load monitor
  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst && bus.ld_valid) begin
      if (ld_q.size() == 0) begin
        chk("load_unexpected", 68'(bus.ld_hit), 68'h0);
      end else begin
        e = ld_q.pop_front();
        chk("ld_hit", 68'(bus.ld_hit), 68'(e[33]));
        chk("ld_conflict", 68'(bus.ld_conflict), 68'(e[32]));
        if (!e[32]) chk("ld_data", 68'(bus.ld_data), 68'(e[31:0]));
      end
    end
  end

  task automatic set_idle();
    bus.st_valid  = 1'b0;
    bus.st_addr   = '0;
    bus.st_data   = '0;
    bus.st_size   = 2'b00;
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_size   = 2'b00;
    bus.drain_ack = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic drive_st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_size  = sz;
  endtask

  task automatic push_st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                         input logic [67:0] e);
    drive_st(a, d, sz);
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic [33:0] e);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = a;
    bus.ld_size  = sz;
    ld_q.push_back(e);
  endtask

  // Ack each drain_req one cycle after it appears, bounded, then require empty.
  task automatic drain_all(input string name);
    bus.cache_busy = 1'b0;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      next();
      if (bus.empty) break;
      next();
      bus.drain_ack = 1'b1;
    end
    @(negedge clk);
    chk(name, 68'(bus.empty), 68'h1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.cache_busy = 1'b0;
    set_idle();
    next();
    next();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_drain_req", 68'(bus.drain_req), 68'h0);
    chk("rst_ld_hit", 68'(bus.ld_hit), 68'h0);
    chk("rst_ld_conflict", 68'(bus.ld_conflict), 68'h0);
    chk("rst_st_ready", 68'(bus.st_ready), 68'h1);
    chk("rst_empty", 68'(bus.empty), 68'h1);
    chk("rst_full", 68'(bus.full), 68'h0);

    // In-order drain with lane replication and byte enables
    next(); push_st(32'h100, 32'hAAAA0001, 2'b10, {32'h100, 32'hAAAA0001, 4'hF});
    next(); push_st(32'h104, 32'h00000055, 2'b00, {32'h104, 32'h55555555, 4'h1});
    next(); push_st(32'h106, 32'h0000BEEF, 2'b01, {32'h104, 32'hBEEFBEEF, 4'hC});
    drain_all("t1_empty");

    // Forwarding hit, then partial-overlap conflict
    bus.cache_busy = 1'b1;
    next(); push_st(32'h200, 32'h12345678, 2'b10, {32'h200, 32'h12345678, 4'hF});
    next(); load(32'h200, 2'b10, {1'b1, 1'b0, 32'h12345678});
    next(); push_st(32'h201, 32'h0000009A, 2'b00, {32'h200, 32'h9A9A9A9A, 4'h2});
    next(); load(32'h200, 2'b01, {1'b0, 1'b1, 32'h0});
    next(); load(32'h201, 2'b00, {1'b1, 1'b0, 32'h9A9A9A9A});
    drain_all("t2_empty");

    // Fill to DEPTH; fifth store refused, ack without drain_req ignored
    bus.cache_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      next();
      push_st(32'h400 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 2'b10,
              {32'h400 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF});
    end
    next();
    drive_st(32'h410, 32'hDEADDEAD, 2'b10);
    bus.drain_ack = 1'b1;
    @(negedge clk);
    chk("t3_full", 68'(bus.full), 68'h1);
    chk("t3_st_ready", 68'(bus.st_ready), 68'h0);
    chk("t3_drain_req", 68'(bus.drain_req), 68'h0);
    next();
    @(negedge clk);
    chk("t3_count_held", 68'(bus.dbg_count), 68'd4);
    bus.cache_busy = 1'b0;
    bus.drain_ack = 1'b1;
    next();
    @(negedge clk);
    chk("t3_st_ready_after_ack", 68'(bus.st_ready), 68'h1);
    chk("t3_count_after_ack", 68'(bus.dbg_count), 68'd3);
    drain_all("t3_empty");

    // Simultaneous push and pop at count 1, wrapping the pointers
    bus.cache_busy = 1'b0;
    next(); push_st(32'h500, 32'h50000000, 2'b10, {32'h500, 32'h50000000, 4'hF});
    for (int k = 1; k <= 2 * DEPTH; k++) begin
      next();
      push_st(32'h500 + 32'(4 * k), 32'h50000000 + 32'(k), 2'b10,
              {32'h500 + 32'(4 * k), 32'h50000000 + 32'(k), 4'hF});
      bus.drain_ack = 1'b1;
      @(negedge clk);
      chk("t4_count", 68'(bus.dbg_count), 68'd1);
    end
    next();
    @(negedge clk);
    chk("t4_count_end", 68'(bus.dbg_count), 68'd1);
    chk("t4_head_addr", 68'(bus.drain_addr), 68'h520);
    drain_all("t4_empty");

    // Reset coincident with drain_ack discards everything
    bus.cache_busy = 1'b1;
    next(); drive_st(32'h600, 32'h60606060, 2'b10);
    next(); drive_st(32'h604, 32'h61616161, 2'b10);
    next(); drive_st(32'h608, 32'h62626262, 2'b10);
    next();
    bus.cache_busy = 1'b0;
    rst = 1'b1;
    bus.drain_ack = 1'b1;
    next();
    rst = 1'b0;
    load(32'h600, 2'b10, {1'b0, 1'b0, 32'h0});
    @(negedge clk);
    chk("t5_empty", 68'(bus.empty), 68'h1);
    chk("t5_drain_req", 68'(bus.drain_req), 68'h0);

    // Same-cycle store is invisible to a load; visible one cycle later
    bus.cache_busy = 1'b1;
    next();
    push_st(32'h300, 32'hCAFEF00D, 2'b10, {32'h300, 32'hCAFEF00D, 4'hF});
    load(32'h300, 2'b10, {1'b0, 1'b0, 32'h0});
    next(); load(32'h300, 2'b10, {1'b1, 1'b0, 32'hCAFEF00D});
    drain_all("t6_empty");

    next();
    @(negedge clk);
    chk("drain_queue_left", 68'(exp_q.size()), 68'h0);
    chk("load_queue_left", 68'(ld_q.size()), 68'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
FIFO store buffer between the memory stage and the data cache port of the memory controller. It accepts committed stores from the memory stage in one cycle, so a store does not wait on the cache. It drains entries to the dcache in program order whenever the memory stage is not using the cache. It forwards buffered data to younger loads, and it flags the partial-overlap cases that must stall.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2
ADDR_W, 32, byte address width
DATA_W, 32, data width; fixed at 32 (4 byte lanes)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
st_valid  input  1  memory stage presents a committed store this cycle
st_addr  input  ADDR_W  store byte address
st_data  input  DATA_W  store data, right-justified
st_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
st_ready  output  1  entry available; store accepted iff st_valid & st_ready
ld_valid  input  1  memory stage performs a load this cycle
ld_addr  input  ADDR_W  load byte address
ld_size  input  2  same encoding as st_size
ld_hit  output  1  load fully covered by buffered data
ld_data  output  DATA_W  lane-aligned word of the covering entry
ld_conflict  output  1  partial overlap; memory stage must stall
cache_busy  input  1  memory stage owns the dcache port this cycle
drain_req  output  1  head entry presented to the dcache
drain_addr  output  ADDR_W  head word address, bits [1:0] = 0
drain_data  output  DATA_W  head lane-aligned data
drain_be  output  4  head byte enables
drain_ack  input  1  dcache has written the head; pop at next edge
empty  output  1  count == 0
full  output  1  count == DEPTH

Behaviour:
- Storage: circular array of {valid, word_addr[ADDR_W-1:2], data[31:0], be[3:0]}.
  - head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
- Push (st_valid & st_ready):
  - be: byte = 1<<a[1:0]; half = 3<<{a[1],0}; word = 4'hF.
  - data is replicated into lanes: byte -> {4{d[7:0]}}; half -> {2{d[15:0]}}; word -> d.
  - The entry is written at tail; tail advances.
  - Alignment is guaranteed upstream and is not checked.
- st_ready = !full. A push is never accepted while full, even if drain_ack arrives the same cycle.
- Drain:
  - drain_req = !empty & !cache_busy.
  - drain_addr, drain_data and drain_be always reflect the head entry.
  - drain_ack is honoured only when drain_req = 1. It then pops the head at the next edge and advances head.
  - drain_ack while drain_req = 0 is ignored.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Forwarding (combinational, from registered entries only; a store pushed in the same cycle is not visible):
  - Compute the load mask the same way as be.
  - Scan valid entries from youngest to oldest for the first entry with equal word_addr and (be & ld_mask) != 0.
  - If that entry's be covers ld_mask: ld_hit = 1, ld_data = entry data.
  - Otherwise: ld_conflict = 1, ld_hit = 0.
  - No overlap with any entry: both 0, ld_data = 0.
  - ld_valid = 0 forces ld_hit = 0 and ld_conflict = 0.
  - The head entry remains forwardable until its pop edge.
- Latency:
  - Store accept to earliest drain_req: 1 cycle.
  - Store visible to a load: the cycle after push.
- Reset:
  - Pointers, count and all valid bits go to 0.
  - In the cycle after reset: drain_req = 0, ld_hit = 0, ld_conflict = 0, st_ready = 1, empty = 1, full = 0.
  - A reset during an outstanding drain discards all entries; a drain_ack in the reset cycle has no effect.
- Ordering: drains always leave in push order. No store merging or coalescing.

Test Plan:
- Reset, then push stores at 0x100 (0xAAAA0001, word), 0x104 (0x55, byte), 0x106 (0xBEEF, half) with cache_busy = 0 and drain_ack one cycle after each drain_req.
  -> Drains appear in order: (0x100, 0xAAAA0001, F), (0x104, 0x55555555, 1), (0x104, 0xBEEFBEEF, C). empty = 1 afterwards.
- Hold cache_busy = 1, push a word 0x12345678 at 0x200, then load a word at 0x200.
  -> ld_hit = 1, ld_data = 0x12345678. Then push a byte 0x9A at 0x201 and load a half at 0x200 -> ld_conflict = 1, ld_hit = 0.
- Hold cache_busy = 1 and push DEPTH (4) stores.
  -> full = 1, st_ready = 0. A fifth st_valid is not accepted. drain_ack in that cycle is ignored (drain_req = 0). Release cache_busy and ack one -> st_ready = 1 next cycle.
- With count = 1, push and drain_ack in the same cycle.
  -> count stays 1, the new entry is at head next cycle, pointers wrap correctly after 2*DEPTH operations.
- With 3 entries buffered and drain_req high, assert rst coincident with drain_ack.
  -> The next cycle shows empty = 1, drain_req = 0, and a load to a previously buffered address gives ld_hit = 0.
- Push a word store to 0x300 and load a word from 0x300 in the same cycle.
  -> ld_hit = 0. The same load one cycle later -> ld_hit = 1.
